// File: rtl/cmp_pkg.sv
// Shared types and helpers for the threshold monitor: state encodings and the
// debounce counter width function.
package cmp_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_NORMAL  = 3'd1,
      ST_RISING  = 3'd2,
      ST_ALARM   = 3'd3,
      ST_FALLING = 3'd4
   } state_e;

   // Counter must hold 0..debounce inclusive.
   function automatic int unsigned cnt_w(input int unsigned debounce);
      return $clog2(debounce + 1);
   endfunction

endpackage

// File: rtl/mag_compare.sv
// Combinational unsigned magnitude comparator of a against b.
module mag_compare #(
   parameter int unsigned WIDTH = 10
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gte,
   output logic             lte,
   output logic             lt
);

   always_comb begin
      lt  = (a < b);
      lte = (a <= b);
      gte = ~lt;
   end

endmodule

// File: rtl/cmp_threshold_monitor.sv
// Sample-stream threshold monitor: registered compare flags and a debounced
// hysteresis alarm. Define CMP_MINMAX_EN to enable running min/max tracking.
module cmp_threshold_monitor
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [WIDTH-1:0]   thr_hi,
   input  logic [WIDTH-1:0]   thr_lo,
   input  logic               clr,
   output logic               out_valid,
   output logic               gte,
   output logic               lte,
   output logic               lt,
   output logic               alarm,
   output logic [STATE_W-1:0] state,
   output logic [WIDTH-1:0]   min_val,
   output logic [WIDTH-1:0]   max_val
);

   localparam int unsigned CW = cnt_w(DEBOUNCE);
   localparam logic [CW-1:0] DEB_CNT = CW'(DEBOUNCE);

   logic          accept;
   logic          hi_gte, hi_lte, hi_lt;
   logic          lo_lt, unused_lo_gte, unused_lo_lte;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          alarm_q, alarm_d;
   logic          out_valid_q;
   logic [2:0]    flags_q;

   assign accept = in_valid & ~clr;

   mag_compare #(.WIDTH(WIDTH)) u_cmp_hi (
      .a   (in_data),
      .b   (thr_hi),
      .gte (hi_gte),
      .lte (hi_lte),
      .lt  (hi_lt)
   );

   mag_compare #(.WIDTH(WIDTH)) u_cmp_lo (
      .a   (in_data),
      .b   (thr_lo),
      .gte (unused_lo_gte),
      .lte (unused_lo_lte),
      .lt  (lo_lt)
   );

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clr) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (in_valid) begin
         case (state_q)
            ST_IDLE, ST_NORMAL: begin
               if (!hi_gte) begin
                  state_d = ST_NORMAL;
                  cnt_d   = '0;
               end else if (DEBOUNCE == 1) begin
                  state_d = ST_ALARM;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_RISING;
                  cnt_d   = CW'(1);
               end
            end
            ST_RISING: begin
               if (!hi_gte) begin
                  state_d = ST_NORMAL;
                  cnt_d   = '0;
               end else if (cnt_inc == DEB_CNT) begin
                  state_d = ST_ALARM;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_inc;
               end
            end
            ST_ALARM: begin
               if (lo_lt) begin
                  if (DEBOUNCE == 1) begin
                     state_d = ST_NORMAL;
                     cnt_d   = '0;
                  end else begin
                     state_d = ST_FALLING;
                     cnt_d   = CW'(1);
                  end
               end
            end
            ST_FALLING: begin
               if (!lo_lt) begin
                  state_d = ST_ALARM;
                  cnt_d   = '0;
               end else if (cnt_inc == DEB_CNT) begin
                  state_d = ST_NORMAL;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_inc;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      alarm_d = (state_d == ST_ALARM) || (state_d == ST_FALLING);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         alarm_q     <= 1'b0;
         out_valid_q <= 1'b0;
         flags_q     <= 3'b000;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alarm_q     <= alarm_d;
         out_valid_q <= accept;
         if (accept) flags_q <= {hi_gte, hi_lte, hi_lt};
      end
   end

   assign out_valid      = out_valid_q;
   assign {gte, lte, lt} = flags_q;
   assign alarm          = alarm_q;
   assign state          = state_q;

`ifdef CMP_MINMAX_EN
   logic [WIDTH-1:0] min_q, max_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q <= '1;
         max_q <= '0;
      end else if (clr) begin
         min_q <= '1;
         max_q <= '0;
      end else if (in_valid) begin
         if (in_data < min_q) min_q <= in_data;
         if (in_data > max_q) max_q <= in_data;
      end
   end

   assign min_val = min_q;
   assign max_val = max_q;
`else
   assign min_val = '0;
   assign max_val = '0;
`endif

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Self-checking bench: directed and random samples on a DEBOUNCE=4 and a DEBOUNCE=1
// instance, checked against a run-length alarm model.
module tb_cmp_threshold_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vld = 1'b0;
   logic       clr = 1'b0;
   logic [9:0] din = '0;
   logic [9:0] thi = '0;
   logic [9:0] tlo = '0;

   logic       ov[2], gte[2], lte[2], lt[2], alm[2];
   logic [2:0] st[2];
   logic [9:0] mn[2], mx[2];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cmp_threshold_monitor #(.WIDTH(10), .DEBOUNCE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_data(din), .thr_hi(thi), .thr_lo(tlo),
      .clr(clr), .out_valid(ov[0]), .gte(gte[0]), .lte(lte[0]), .lt(lt[0]), .alarm(alm[0]),
      .state(st[0]), .min_val(mn[0]), .max_val(mx[0])
   );

   cmp_threshold_monitor #(.WIDTH(10), .DEBOUNCE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_data(din), .thr_hi(thi), .thr_lo(tlo),
      .clr(clr), .out_valid(ov[1]), .gte(gte[1]), .lte(lte[1]), .lt(lt[1]), .alarm(alm[1]),
      .state(st[1]), .min_val(mn[1]), .max_val(mx[1])
   );

   // Reference model: alarm bit plus length of the current qualifying run.
   int         deb[2] = '{4, 1};
   bit         m_ov;
   bit   [2:0] m_flags;
   bit         m_alarm[2];
   int         m_run[2];
   bit         m_seen[2];
   logic [9:0] m_min, m_max;

   function automatic int exp_state(input int k);
      if (m_alarm[k]) return (m_run[k] > 0) ? 4 : 3;
      if (m_run[k] > 0) return 2;
      return m_seen[k] ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_ov = 0; m_flags = 3'b000; m_min = 10'h3FF; m_max = 10'h000;
      for (int k = 0; k < 2; k++) begin
         m_alarm[k] = 0; m_run[k] = 0; m_seen[k] = 0;
      end
   endtask

   task automatic model_clock(input bit v, input bit c, input logic [9:0] d,
                              input logic [9:0] hi, input logic [9:0] lo);
      if (c) begin
         m_ov = 0; m_min = 10'h3FF; m_max = 10'h000;
         for (int k = 0; k < 2; k++) begin
            m_alarm[k] = 0; m_run[k] = 0; m_seen[k] = 0;
         end
      end else if (v) begin
         m_ov = 1;
         m_flags = {d >= hi, d <= hi, d < hi};
         if (d < m_min) m_min = d;
         if (d > m_max) m_max = d;
         for (int k = 0; k < 2; k++) begin
            m_seen[k] = 1;
            if ((!m_alarm[k] && d >= hi) || (m_alarm[k] && d < lo)) begin
               m_run[k]++;
               if (m_run[k] == deb[k]) begin
                  m_alarm[k] = ~m_alarm[k];
                  m_run[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
         end
      end else begin
         m_ov = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [9:0] emin, emax;
`ifdef CMP_MINMAX_EN
      emin = m_min; emax = m_max;
`else
      emin = 10'h000; emax = 10'h000;
`endif
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d out_valid", deb[k]), 32'(ov[k]), 32'(m_ov));
         chk($sformatf("d%0d flags", deb[k]), 32'({gte[k], lte[k], lt[k]}), 32'(m_flags));
         chk($sformatf("d%0d alarm", deb[k]), 32'(alm[k]), 32'(m_alarm[k]));
         chk($sformatf("d%0d state", deb[k]), 32'(st[k]), 32'(exp_state(k)));
         chk($sformatf("d%0d min", deb[k]), 32'(mn[k]), 32'(emin));
         chk($sformatf("d%0d max", deb[k]), 32'(mx[k]), 32'(emax));
      end
   endtask

   task automatic step(input bit v, input logic [9:0] d, input bit c);
      @(negedge clk);
      vld = v; din = d; clr = c;
      @(posedge clk);
      model_clock(v, c, d, thi, tlo);
      #1;
      check_all();
   endtask

   task automatic samples(input logic [9:0] d, input int n);
      for (int i = 0; i < n; i++) step(1'b1, d, 1'b0);
   endtask

   initial begin
      model_reset();
      thi = 10'h200; tlo = 10'h100;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Compare boundaries around thr_hi
      step(1'b1, 10'h1FF, 1'b0); chk("cmp_below", 32'({gte[0], lte[0], lt[0]}), 32'h3);
      step(1'b1, 10'h200, 1'b0); chk("cmp_equal", 32'({gte[0], lte[0], lt[0]}), 32'h6);
      step(1'b1, 10'h201, 1'b0); chk("cmp_above", 32'({gte[0], lte[0], lt[0]}), 32'h4);
      step(1'b0, 10'h000, 1'b0); chk("flags_hold", 32'({gte[0], lte[0], lt[0]}), 32'h4);

      // Debounced rise across an idle gap
      step(1'b0, 10'h000, 1'b1);
      samples(10'h250, 3);
      for (int i = 0; i < 5; i++) step(1'b0, 10'h000, 1'b0);
      chk("rise_pending", 32'(alm[0]), 32'h0);
      samples(10'h250, 1);
      chk("rise_alarm", 32'(alm[0]), 32'h1);

      // Broken rise
      step(1'b0, 10'h000, 1'b1);
      samples(10'h250, 3);
      samples(10'h100, 1);
      chk("broken_state", 32'(st[0]), 32'h1);
      chk("broken_alarm", 32'(alm[0]), 32'h0);

      // Hysteresis hold, broken fall, then full fall
      samples(10'h250, 4);
      samples(10'h150, 10);
      chk("hyst_hold", 32'(alm[0]), 32'h1);
      samples(10'h0FF, 3);
      samples(10'h150, 1);
      chk("fall_broken", 32'(st[0]), 32'h3);
      samples(10'h0FF, 3);
      chk("fall_pending", 32'(alm[0]), 32'h1);
      samples(10'h0FF, 1);
      chk("fall_done", 32'(alm[0]), 32'h0);

      // Asynchronous reset in the middle of a cycle while alarmed
      samples(10'h250, 4);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_alarm", 32'(alm[0]), 32'h0);
      chk("arst_state", 32'(st[0]), 32'h0);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // clr wins over a simultaneous sample
      samples(10'h005, 1);
      step(1'b1, 10'h3FF, 1'b1);
      chk("clr_drop_ov", 32'(ov[0]), 32'h0);
      chk("clr_drop_max", 32'(mx[0]), 32'h0);

      // Min/max tracking
      samples(10'h005, 1);
      samples(10'h3FF, 1);
      samples(10'h000, 1);

      // DEBOUNCE=1 goes straight from NORMAL to ALARM
      step(1'b0, 10'h000, 1'b1);
      samples(10'h100, 1);
      samples(10'h250, 1);
      chk("deb1_alarm_state", 32'(st[1]), 32'h3);

      // Random traffic with occasional threshold changes and clears
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            thi = 10'($urandom_range(10'h080, 10'h300));
            tlo = ($urandom_range(0, 9) == 0) ? 10'(thi + 10'h040) : 10'(thi - 10'h080);
         end
         case ($urandom_range(0, 3))
            0: din = 10'($urandom);
            1: din = 10'(thi + 10'($urandom_range(0, 3)) - 10'd1);
            2: din = 10'(tlo + 10'($urandom_range(0, 3)) - 10'd2);
            default: din = 10'(thi + 10'h020);
         endcase
         step($urandom_range(0, 3) != 0, din, $urandom_range(0, 49) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
